// File: rtl/ntt_bank_addr_gen_if.sv
// rtl/ntt_bank_addr_gen_if.sv - control/beat bundle of the NTT bank address generator
// master = generator side, slave = consumer side.
interface ntt_bank_addr_gen_if #(
  parameter int addr_width = 7
);
  logic                  start;
  logic                  out_ready;
  logic                  out_valid;
  logic [addr_width-1:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic [2:0]            sel_a_0, sel_a_1, sel_a_2, sel_a_3;
  logic [2:0]            sel_a_4, sel_a_5, sel_a_6, sel_a_7;
  logic [3:0]            stage;
  logic                  last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, out_ready,
    output out_valid, b0, b1, b2, b3, b4, b5, b6, b7,
    output sel_a_0, sel_a_1, sel_a_2, sel_a_3, sel_a_4, sel_a_5, sel_a_6, sel_a_7,
    output stage, last, busy, done
  );

  modport slave (
    output start, out_ready,
    input  out_valid, b0, b1, b2, b3, b4, b5, b6, b7,
    input  sel_a_0, sel_a_1, sel_a_2, sel_a_3, sel_a_4, sel_a_5, sel_a_6, sel_a_7,
    input  stage, last, busy, done
  );
endinterface

// File: rtl/ntt_bank_addr_gen.sv
// rtl/ntt_bank_addr_gen.sv - per-beat bank address / lane select generator for an in-place radix-2 NTT
// Counters (c_q, t_q) always describe the beat currently held in the output registers.
module ntt_bank_addr_gen #(
  parameter int addr_width = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_bank_addr_gen_if.master   bus
);
  localparam int logn = addr_width + 3;
  localparam logic [3:0] t_top = 4'(logn - 1);
  localparam logic [addr_width-1:0] c_max = '1;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  typedef logic [logn-1:0] idx_t;

  logic [1:0]            state_q, state_d;
  logic [addr_width-1:0] c_q, c_d;
  logic [3:0]            t_q, t_d;
  logic                  out_valid_q, out_valid_d;
  logic                  last_q, last_d;
  logic [3:0]            stage_q, stage_d;
  logic [addr_width-1:0] addr_q [8];
  logic [addr_width-1:0] addr_d [8];
  logic [2:0]            sel_q [8];
  logic [2:0]            sel_d [8];

  logic                  accept;
  logic                  load;
  logic                  finish;
  idx_t                  low_mask;
  idx_t                  m_ext [4];
  idx_t                  lane_idx [8];
  logic [2:0]            beat_sel [8];

  function automatic logic [2:0] bank_of(input idx_t i);
    return {^i[logn-1:2], i[1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    t_d     = t_q;
    load    = 1'b0;
    finish  = 1'b0;
    accept  = out_valid_q & bus.out_ready;
    case (state_q)
      st_idle: begin
        if (bus.start) begin
          state_d = st_run;
          c_d     = '0;
          t_d     = t_top;
          load    = 1'b1;
        end
      end
      st_run: begin
        if (accept) begin
          if (last_q) begin
            state_d = st_done;
            finish  = 1'b1;
          end else begin
            load = 1'b1;
            if (c_q == c_max) begin
              c_d = '0;
              t_d = t_q - 4'd1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      st_done: begin
        state_d = st_idle;
        c_d     = '0;
        t_d     = t_top;
      end
      default: state_d = st_idle;
    endcase
  end

  // Lane pairs for the beat about to be loaded: x has a 0 spliced in at bit t, its partner sets it.
  always_comb begin
    low_mask = (idx_t'(1) << t_d) - idx_t'(1);
    for (int q = 0; q < 4; q++) begin
      m_ext[q]          = idx_t'({c_d, 2'(q)});
      lane_idx[2*q]     = ((m_ext[q] & ~low_mask) << 1) | (m_ext[q] & low_mask);
      lane_idx[2*q + 1] = lane_idx[2*q] | (idx_t'(1) << t_d);
    end
    beat_sel = '{default: 3'd0};
    for (int l = 0; l < 8; l++) begin
      beat_sel[bank_of(lane_idx[l])] = 3'(l);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    last_d      = last_q;
    stage_d     = stage_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    if (finish) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      last_d      = (t_d == 4'd0) && (c_d == c_max);
      stage_d     = t_d;
      for (int l = 0; l < 8; l++) begin
        addr_d[l] = lane_idx[l][logn-1:3];
      end
      sel_d = beat_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= st_idle;
      c_q         <= '0;
      t_q         <= t_top;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      stage_q     <= '0;
      for (int l = 0; l < 8; l++) begin
        addr_q[l] <= '0;
        sel_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      stage_q     <= stage_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.b0        = addr_q[0];
  assign bus.b1        = addr_q[1];
  assign bus.b2        = addr_q[2];
  assign bus.b3        = addr_q[3];
  assign bus.b4        = addr_q[4];
  assign bus.b5        = addr_q[5];
  assign bus.b6        = addr_q[6];
  assign bus.b7        = addr_q[7];
  assign bus.sel_a_0   = sel_q[0];
  assign bus.sel_a_1   = sel_q[1];
  assign bus.sel_a_2   = sel_q[2];
  assign bus.sel_a_3   = sel_q[3];
  assign bus.sel_a_4   = sel_q[4];
  assign bus.sel_a_5   = sel_q[5];
  assign bus.sel_a_6   = sel_q[6];
  assign bus.sel_a_7   = sel_q[7];
  assign bus.stage     = stage_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state_q != st_idle);
  assign bus.done      = (state_q == st_done);
endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// tb/tb_ntt_bank_addr_gen.sv - scoreboard bench for ntt_bank_addr_gen (addr_width = 7)
// Stimulus pushes expected beats into a queue; the negedge monitor pops and compares on every accept.
module tb_ntt_bank_addr_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_bank_addr_gen_if #(.addr_width(7)) bus ();
  ntt_bank_addr_gen #(.addr_width(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0][6:0] b;
    logic [7:0][2:0] s;
    logic [3:0]      stage;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  beat_t first_c, last_c, snap;
  int    n_checks = 0;
  int    n_pass = 0;
  int    beats_seen = 0;
  int    done_count = 0;
  bit    exp_done = 0, exp_idle = 0, stalled = 0, rand_ready = 0;
  bit    seen [8][128];
  int    first_sel [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  int    first_b   [8] = '{0, 64, 0, 64, 0, 64, 0, 64};
  int    last_sel  [8] = '{4, 5, 6, 7, 0, 1, 2, 3};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp_v, $time);
  endtask

  function automatic beat_t get_out();
    beat_t r;
    r.b[0] = bus.b0; r.b[1] = bus.b1; r.b[2] = bus.b2; r.b[3] = bus.b3;
    r.b[4] = bus.b4; r.b[5] = bus.b5; r.b[6] = bus.b6; r.b[7] = bus.b7;
    r.s[0] = bus.sel_a_0; r.s[1] = bus.sel_a_1; r.s[2] = bus.sel_a_2; r.s[3] = bus.sel_a_3;
    r.s[4] = bus.sel_a_4; r.s[5] = bus.sel_a_5; r.s[6] = bus.sel_a_6; r.s[7] = bus.sel_a_7;
    r.stage = bus.stage;
    r.last  = bus.last;
    return r;
  endfunction

  function automatic beat_t model_beat(input int t, input int c);
    beat_t r;
    int idx [8];
    int m, low, x, par, bk;
    r = '0;
    for (int q = 0; q < 4; q++) begin
      m   = 4 * c + q;
      low = m & ((1 << t) - 1);
      x   = low + (m - low) * 2;
      idx[2*q]     = x;
      idx[2*q + 1] = x + (1 << t);
    end
    for (int l = 0; l < 8; l++) r.b[l] = 7'(idx[l] >> 3);
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < 8; l++) begin
        par = 0;
        for (int bit_i = 2; bit_i < 10; bit_i++) par = par ^ ((idx[l] >> bit_i) & 1);
        bk = par * 4 + (idx[l] % 4);
        if (bk == k) r.s[k] = 3'(l);
      end
    end
    r.stage = 4'(t);
    r.last  = (t == 0) && (c == 127);
    return r;
  endfunction

  task automatic push_run();
    for (int t = 9; t >= 0; t--)
      for (int c = 0; c < 128; c++) exp_q.push_back(model_beat(t, c));
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.start = 1'b1;
    push_run();
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done_count(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("run_complete", done_count, target);
  endtask

  always @(negedge clk) begin : monitor
    beat_t cur, e;
    logic [7:0] pm;
    bit dup;
    int cnt;
    cur = get_out();
    if (rst) begin
      exp_q.delete();
      beats_seen = 0;
      stalled = 0;
      exp_done = 0;
      exp_idle = 0;
    end else begin
      if (stalled) chk("stall_hold", cur, snap);
      if (exp_idle) begin
        chk("busy_after_done", bus.busy, 1'b0);
        exp_idle = 0;
      end
      if (exp_done) begin
        chk("done_pulse", bus.done, 1'b1);
        if (bus.done) done_count++;
        exp_done = 0;
        exp_idle = 1;
      end else if (bus.done) begin
        chk("done_spurious", bus.done, 1'b0);
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap = cur;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        if (beats_seen == 0) chk("first_beat", cur, first_c);
        if (beats_seen == 1279) chk("last_beat", cur, last_c);
        pm = '0;
        for (int k = 0; k < 8; k++) pm[cur.s[k]] = 1'b1;
        chk("sel_permutation", pm, 8'hff);
        if (beats_seen % 128 == 0)
          for (int k = 0; k < 8; k++) for (int a = 0; a < 128; a++) seen[k][a] = 0;
        dup = 0;
        for (int k = 0; k < 8; k++) begin
          if (seen[k][cur.b[cur.s[k]]]) dup = 1;
          seen[k][cur.b[cur.s[k]]] = 1;
        end
        chk("bank_addr_unique", dup, 1'b0);
        if (beats_seen % 128 == 127) begin
          cnt = 0;
          for (int k = 0; k < 8; k++) for (int a = 0; a < 128; a++) cnt += int'(seen[k][a]);
          chk("stage_cover", cnt, 1024);
        end
        if (cur.last) begin
          exp_done = 1;
          beats_seen = 0;
        end else begin
          beats_seen++;
        end
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    first_c = '0;
    last_c = '0;
    for (int l = 0; l < 8; l++) begin
      first_c.b[l] = 7'(first_b[l]);
      first_c.s[l] = 3'(first_sel[l]);
      last_c.b[l]  = 7'd127;
      last_c.s[l]  = 3'(last_sel[l]);
    end
    first_c.stage = 4'd9;
    last_c.stage  = 4'd0;
    last_c.last   = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", get_out(), '0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);

    // full run, no backpressure
    start_pulse();
    wait_done_count(1, 1400);
    repeat (3) @(negedge clk);

    // random 50% backpressure
    rand_ready = 1;
    start_pulse();
    fork
      begin
        wait_done_count(2, 6000);
        rand_ready = 0;
      end
      begin
        while (rand_ready) begin
          @(posedge clk); #1;
          if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of a run
    start_pulse();
    n = 0;
    while (beats_seen < 300 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_beat_300", beats_seen >= 300, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", get_out(), '0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_count, 2);
    start_pulse();
    wait_done_count(3, 1400);
    repeat (3) @(negedge clk);

    // start held high and re-pulsed while busy
    @(posedge clk); #1;
    bus.start = 1'b1;
    push_run();
    n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 100) bus.start = 1'b0;
      if (n == 110) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    wait_done_count(4, 10);
    repeat (20) @(negedge clk);
    chk("held_start_idle", bus.busy, 1'b0);
    chk("held_start_single_run", exp_q.size(), 0);

    // fresh run after idle
    start_pulse();
    wait_done_count(5, 1400);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
